// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/stall/flush controller for the 5-stage MIPS pipeline.
// Handles load-use bubbles, wrong-path squashes, EOP drain/halt, single-step and counters.
`default_nettype none

module pipeline_sequencer #(
  parameter int CW        = 32,
  parameter int DRAIN_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_uses_rt,
  input  logic          id_jump,
  input  logic          id_eop,
  input  logic          ex_mem_to_reg,
  input  logic [4:0]    ex_rt,
  input  logic          ex_branch_taken,
  input  logic          wb_eop,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          pipe_en,
  output logic          pipe_clear,
  output logic          running,
  output logic          halted,
  output logic          drain_err,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  state_t        state, state_nxt;
  logic          step_q;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          advance;
  logic          luh;
  logic          cycle_inc, stall_inc, cnt_clr, err_set, err_clr;

  assign advance = step_mode ? (step & ~step_q) : 1'b1;

  assign luh = ex_mem_to_reg && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign running = (state == RUN) || (state == DRAIN);
  assign halted  = (state == HALTED);

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pipe_en       = 1'b0;
    pipe_clear    = 1'b0;
    cycle_inc     = 1'b0;
    stall_inc     = 1'b0;
    cnt_clr       = 1'b0;
    err_set       = 1'b0;
    err_clr       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pipe_clear = 1'b1;
          state_nxt  = RUN;
        end
      end

      RUN: begin
        if (advance) begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          pipe_en   = 1'b1;
          cycle_inc = 1'b1;
          if (ex_branch_taken) begin
            // ID holds a wrong-path instruction: squash it regardless of hazards
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (luh) begin
            // a stalled jump stays in ID and is re-evaluated next cycle
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            if (id_jump) if_id_flush = 1'b1;
            if (id_eop) begin
              state_nxt     = DRAIN;
              drain_cnt_nxt = '0;
            end
          end
          if (wb_eop) state_nxt = HALTED;
        end
      end

      DRAIN: begin
        if (advance) begin
          if_id_en      = 1'b1;
          if_id_flush   = 1'b1;
          pipe_en       = 1'b1;
          cycle_inc     = 1'b1;
          drain_cnt_nxt = drain_cnt + 1'b1;
          if (wb_eop) begin
            state_nxt = HALTED;
          end else if (drain_cnt == DRAIN_LAST) begin
            state_nxt = HALTED;
            err_set   = 1'b1;
          end
        end
      end

      HALTED: begin
        if (start) begin
          pipe_clear = 1'b1;
          cnt_clr    = 1'b1;
          err_clr    = 1'b1;
          state_nxt  = RUN;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      step_q    <= 1'b0;
      drain_cnt <= '0;
      drain_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_q    <= step;
      drain_cnt <= drain_cnt_nxt;
      if (err_clr)      drain_err <= 1'b0;
      else if (err_set) drain_err <= 1'b1;
    end
  end

  // both counters saturate at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (cnt_clr) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (cycle_inc && (cycle_count != {CW{1'b1}})) cycle_count <= cycle_count + 1'b1;
      if (stall_inc && (stall_count != {CW{1'b1}})) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run/stall/flush controller for the 5-stage MIPS pipeline. It consumes decoded control from the ID and EX stages plus the end-of-program flag and drives the PC and stage-register enables and flushes. It inserts load-use bubbles, squashes wrong-path fetches on jumps and taken branches, and drains the pipeline after EOP before halting. It also provides a single-step mode for the debug unit, plus cycle and stall counters.

## Interface
- CW, 32: width of cycle_count and stall_count.
- DRAIN_MAX, 8: max advances allowed in DRAIN before forced halt.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  level-sampled pulse: begin execution (IDLE) or restart (HALTED).
- step_mode  in  1  1 = advance only on step pulses; 0 = free-running.
- step  in  1  debug step request; rising edge = one advance.
- id_rs, id_rt  in  5  source registers of the instruction in ID.
- id_uses_rt  in  1  rt is a source (R-type, branch, store).
- id_jump  in  1  J decoded in ID.
- id_eop  in  1  EOP opcode (6'b111111) decoded in ID.
- ex_mem_to_reg  in  1  EX instruction is a load.
- ex_rt  in  5  destination register of the EX load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- wb_eop  in  1  EOP instruction is in WB.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_flush  out  1  ID/EX register loads a NOP (all control zero).
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers.
- pipe_clear  out  1  one-cycle synchronous clear of all stage registers and PC.
- running, halted, drain_err  out  1  status.
- cycle_count, stall_count  out  CW  saturating counters.

## Operation
- States: IDLE, RUN, DRAIN, HALTED. They are encoded in a registered state register.
- Step edge detection:
  - step_q is registered.
  - advance = step_mode ? (step & ~step_q) : 1.
  - Holding step high yields exactly one advance.
- In every state, when advance is 0, all enables and flushes are 0. The pipeline is frozen.
- IDLE:
  - Outputs are 0.
  - start=1 → pipe_clear=1 this cycle; next state is RUN.
- RUN, when advance=1:
  - Baseline outputs: pc_en=1, if_id_en=1, pipe_en=1.
  - Load-use hazard: luh = ex_mem_to_reg & (ex_rt≠0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - luh → pc_en=0, if_id_en=0, id_ex_flush=1, stall_count+1.
  - id_jump → if_id_flush=1.
  - ex_branch_taken → if_id_flush=1 and id_ex_flush=1, with pc_en=1. This overrides luh and id_jump, because the ID instruction is on the wrong path.
  - id_eop & ~luh & ~ex_branch_taken → next state is DRAIN and drain_cnt=0. An EOP that is squashed or stalled does not trigger the transition.
  - wb_eop → HALTED. This is a defensive path.
- DRAIN, when advance=1:
  - Outputs: pc_en=0, if_id_en=1, if_id_flush=1, pipe_en=1. Bubbles follow the EOP.
  - drain_cnt+1 on each advance.
  - wb_eop → HALTED.
  - drain_cnt==DRAIN_MAX-1 without wb_eop → HALTED with drain_err=1.
- HALTED:
  - All enables are 0 and halted=1.
  - start → pipe_clear=1, counters and drain_err cleared, next state is RUN.
- Counters:
  - cycle_count +1 per advance in RUN/DRAIN. It saturates at 2^CW−1.
  - stall_count +1 per luh stall cycle. It saturates.
  - Counters are cleared only by reset or a restart from HALTED.
- running=1 in RUN and DRAIN.

## Timing
- Reset values:
  - State IDLE; step_q=0; drain_cnt=0.
  - All outputs 0, including counters, halted and drain_err.
- Enable and flush outputs are combinational from state, advance and hazard inputs. They are valid within the same cycle and are consumed at the next rising edge.
- Status outputs and counters are registered and update one cycle after the event.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed slots. A jump costs 1.
- Latency from EOP in ID to halted=1 is 4 advances: EX, MEM, WB, then the registered state update.
- Reset asserted mid-RUN or mid-DRAIN → IDLE asynchronously. No drain is performed and counters clear.
- start while in RUN or DRAIN is ignored.
- step_mode may toggle at any cycle and takes effect the same cycle.

## Test plan
- Load-use: LW r2 in EX, ADD using r2 in ID → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1. With ex_rt=0 → no stall.
- Branch vs hazard: ex_branch_taken=1 together with luh=1 → pc_en=1, if_id_flush=1, id_ex_flush=1; stall_count unchanged.
- EOP drain: id_eop at cycle N, wb_eop at N+3 → pc_en=0 from N+1, halted=1 at N+4, drain_err=0. A second start → pipe_clear pulse and counters at 0.
- Drain timeout: DRAIN_MAX=8, wb_eop never asserted → halted=1 and drain_err=1 after 8 advances.
- Single step: step_mode=1, step held high 5 cycles → exactly one cycle with enables active; cycle_count +1.
- Reset mid-DRAIN → all outputs 0 immediately (asynchronous); after release, state is IDLE until start.
